// File: rtl/irq_controller_if.sv
// Bus and pipeline-handshake bundle for irq_controller.
// Handshake: irq_req holds until the pipeline answers with a one-cycle irq_ack
// (epc_in valid with it); in_service then holds until a one-cycle eret.
interface irq_controller_if #(
  parameter int ID_W = 3
);
  logic            rd;
  logic            wr;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            irq_req;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack;
  logic            eret;
  logic [31:0]     epc_in;
  logic            in_service;

  modport master (
    output rd, wr, addr, wdata, irq_ack, eret, epc_in,
    input  rdata, irq_req, irq_id, in_service
  );

  modport slave (
    input  rd, wr, addr, wdata, irq_ack, eret, epc_in,
    output rdata, irq_req, irq_id, in_service
  );
endinterface

// File: rtl/irq_controller.sv
// Prioritised, memory-mapped interrupt controller with per-source level/edge mode
// and a request/acknowledge/return handshake to the pipeline.
module irq_controller #(
  parameter int          NUM_SRC = 8,
  parameter int          ID_W    = 3,
  parameter logic [31:0] BASE    = 32'h4000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  irq_controller_if.slave    bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [31:0]        epc_q, epc_d;
  logic               gctrl_q, gctrl_d;

  logic [31:0]        offset;
  logic               hit;
  logic [2:0]         reg_sel;
  logic               we_enable, we_mode, we_pend, we_epc, we_gctrl;
  logic [NUM_SRC-1:0] eligible, rise, w1c, ack_clr, mode_chg, edge_keep;
  logic [ID_W-1:0]    winner;
  logic               ack_take;

  assign offset   = bus.addr - BASE;
  assign hit      = (offset < 32'd24) && (offset[1:0] == 2'b00);
  assign reg_sel  = offset[4:2];

  assign we_enable = bus.wr && hit && (reg_sel == 3'd0);
  assign we_mode   = bus.wr && hit && (reg_sel == 3'd1);
  assign we_pend   = bus.wr && hit && (reg_sel == 3'd2);
  assign we_epc    = bus.wr && hit && (reg_sel == 3'd4);
  assign we_gctrl  = bus.wr && hit && (reg_sel == 3'd5);

  assign eligible = pend_q & enable_q & {NUM_SRC{gctrl_q}};
  assign ack_take = (state_q == S_REQ) && bus.irq_ack;

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = ack_take && (irq_id_q == ID_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    irq_id_d   = irq_id_q;
    enable_d   = enable_q;
    mode_d     = mode_q;
    gctrl_d    = gctrl_q;
    epc_d      = epc_q;
    src_prev_d = irq_src;
    if (we_enable) enable_d = bus.wdata[NUM_SRC-1:0];
    if (we_mode)   mode_d   = bus.wdata[NUM_SRC-1:0];
    if (we_gctrl)  gctrl_d  = bus.wdata[0];
    if (we_epc)    epc_d    = bus.wdata;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          state_d  = S_REQ;
          irq_id_d = winner;
        end
      end
      S_REQ: begin
        // An ack commits the current id and its PC, even if a bus write targets EPC.
        if (bus.irq_ack) begin
          state_d = S_SERVICE;
          epc_d   = bus.epc_in;
        end else if (|eligible) begin
          irq_id_d = winner;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (bus.eret) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Level bits mirror the sampled source; edge bits are sticky, and a new edge beats any clear.
  assign mode_chg  = mode_d ^ mode_q;
  assign rise      = irq_src & ~src_prev_q;
  assign w1c       = we_pend ? bus.wdata[NUM_SRC-1:0] : '0;
  assign edge_keep = pend_q & ~w1c & ~ack_clr;
  assign pend_d    = (mode_d & ~mode_chg & (rise | edge_keep)) | (~mode_d & irq_src);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      irq_id_q   <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      pend_q     <= '0;
      src_prev_q <= '0;
      epc_q      <= '0;
      gctrl_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_id_q   <= irq_id_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      src_prev_q <= src_prev_d;
      epc_q      <= epc_d;
      gctrl_q    <= gctrl_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rd && hit) begin
      case (reg_sel)
        3'd0:    bus.rdata = 32'(enable_q);
        3'd1:    bus.rdata = 32'(mode_q);
        3'd2:    bus.rdata = 32'(pend_q);
        3'd3:    bus.rdata = {23'd0, state_q == S_SERVICE, 8'(irq_id_q)};
        3'd4:    bus.rdata = epc_q;
        3'd5:    bus.rdata = {31'd0, gctrl_q};
        default: bus.rdata = '0;
      endcase
    end
  end

  assign bus.irq_req    = (state_q == S_REQ);
  assign bus.in_service = (state_q == S_SERVICE);
  assign bus.irq_id     = irq_id_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a spec-level model checked every cycle,
// plus hand-computed literal expectations along the test plan.
module tb_irq_controller;
  localparam int          NUM_SRC = 8;
  localparam int          ID_W    = 3;
  localparam logic [31:0] BASE    = 32'h4000_0100;
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_src = 8'h00;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_pass = 0;
  bit         started = 1'b0;

  irq_controller_if #(.ID_W(ID_W)) bus();

  irq_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W), .BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  int          m_state, m_id;
  logic [7:0]  m_en, m_mode, m_pend, m_prev;
  logic [31:0] m_epc;
  logic        m_gen;

  always @(posedge clk) begin : model
    logic [7:0]  elig, nmode, npend, w1c, ackc;
    logic [31:0] off;
    bit          whit;
    int          win;
    started = 1'b1;
    if (reset) begin
      m_state = M_IDLE; m_id = 0; m_en = 0; m_mode = 0;
      m_pend = 0; m_prev = 0; m_epc = 0; m_gen = 0;
    end else begin
      elig = m_pend & m_en & {8{m_gen}};
      win = -1;
      for (int i = 7; i >= 0; i--) if (elig[i]) win = i;
      off   = bus.addr - BASE;
      whit  = bus.wr && (off < 24) && (off[1:0] == 2'b00);
      nmode = (whit && off == 4) ? bus.wdata[7:0] : m_mode;
      w1c   = (whit && off == 8) ? bus.wdata[7:0] : 8'h00;
      ackc  = 8'h00;
      if (m_state == M_REQ && bus.irq_ack) ackc[m_id] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (nmode[i] != m_mode[i]) npend[i] = nmode[i] ? 1'b0 : irq_src[i];
        else if (!nmode[i])        npend[i] = irq_src[i];
        else npend[i] = (irq_src[i] && !m_prev[i]) || (m_pend[i] && !w1c[i] && !ackc[i]);
      end
      if (whit && off == 0)  m_en  = bus.wdata[7:0];
      if (whit && off == 16) m_epc = bus.wdata;
      if (whit && off == 20) m_gen = bus.wdata[0];
      case (m_state)
        M_IDLE: if (win >= 0) begin m_state = M_REQ; m_id = win; end
        M_REQ: begin
          if (bus.irq_ack) begin m_state = M_SVC; m_epc = bus.epc_in; end
          else if (win >= 0) m_id = win;
          else m_state = M_IDLE;
        end
        default: if (bus.eret) m_state = M_IDLE;
      endcase
      m_mode = nmode;
      m_pend = npend;
      m_prev = irq_src;
    end
  end

  function automatic logic [31:0] m_read(logic r, logic [31:0] a);
    logic [31:0] off = a - BASE;
    if (!r || off >= 24 || off[1:0] != 2'b00) return 32'd0;
    case (off)
      0:       return {24'd0, m_en};
      4:       return {24'd0, m_mode};
      8:       return {24'd0, m_pend};
      12:      return {23'd0, m_state == M_SVC, 5'd0, 3'(m_id)};
      16:      return m_epc;
      20:      return {31'd0, m_gen};
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp, logic [31:0] mdl);
    check(name, act, exp);
    check({name, "_model"}, mdl, exp);
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("cyc_irq_req", 32'(bus.irq_req), 32'(m_state == M_REQ));
      check("cyc_irq_id", 32'(bus.irq_id), 32'(m_id));
      check("cyc_in_service", 32'(bus.in_service), 32'(m_state == M_SVC));
      check("cyc_rdata", bus.rdata, m_read(bus.rd, bus.addr));
      check("cyc_idle", 32'(dbg_state == 2'd0), 32'(m_state == M_IDLE));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- drivers ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(logic [31:0] off, logic [31:0] d);
    bus.addr = BASE + off; bus.wdata = d; bus.wr = 1'b1;
    tick(1);
    bus.wr = 1'b0;
  endtask

  task automatic rd_lit(string name, logic [31:0] off, logic [31:0] exp);
    bus.addr = BASE + off; bus.rd = 1'b1;
    #1;
    lit(name, bus.rdata, exp, m_read(1'b1, BASE + off));
    bus.rd = 1'b0;
  endtask

  task automatic out_lit(string name, int req, int id, int svc);
    lit({name, "_req"}, 32'(bus.irq_req), 32'(req), 32'(m_state == M_REQ));
    if (id >= 0) lit({name, "_id"}, 32'(bus.irq_id), 32'(id), 32'(m_id));
    lit({name, "_svc"}, 32'(bus.in_service), 32'(svc), 32'(m_state == M_SVC));
  endtask

  initial begin
    bus.rd = 0; bus.wr = 0; bus.addr = 0; bus.wdata = 0;
    bus.irq_ack = 0; bus.eret = 0; bus.epc_in = 0;

    // reset then idle
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    out_lit("rst", 0, 0, 0);
    irq_src = 8'hFF; tick(1); irq_src = 8'h00; tick(3);
    out_lit("idle", 0, 0, 0);
    rd_lit("idle_pend", 8, 0);
    rd_lit("idle_epc", 16, 0);

    // edge source + ack
    wr_reg(0, 32'hFF); wr_reg(4, 32'h04); wr_reg(20, 1);
    irq_src = 8'h04; tick(1); irq_src = 8'h00;
    rd_lit("edge_pend", 8, 32'h04);
    out_lit("edge_early", 0, 0, 0);
    tick(1);
    out_lit("edge", 1, 2, 0);
    bus.irq_ack = 1'b1; bus.epc_in = 32'h0000_0238; tick(1); bus.irq_ack = 1'b0;
    out_lit("ack", 0, 2, 1);
    rd_lit("ack_epc", 16, 32'h238);
    rd_lit("ack_pend", 8, 0);
    rd_lit("ack_status", 12, 32'h102);
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    out_lit("eret", 0, 2, 0);

    // priority change while requesting
    irq_src = 8'h20; tick(2);
    out_lit("lvl5", 1, 5, 0);
    irq_src = 8'h22; tick(1);
    out_lit("pre1_a", 1, 5, 0);
    tick(1);
    out_lit("pre1_b", 1, 1, 0);
    bus.irq_ack = 1'b1; bus.epc_in = 32'h1000; tick(1); bus.irq_ack = 1'b0;
    irq_src = 8'h23; tick(2);
    out_lit("frozen", 0, 1, 1);

    // no nesting, replay after eret
    irq_src = 8'h00;
    wr_reg(4, 32'h0C);
    irq_src = 8'h08; tick(1); irq_src = 8'h00; tick(2);
    out_lit("nest", 0, 1, 1);
    rd_lit("nest_pend", 8, 32'h08);
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    out_lit("gap", 0, 1, 0);
    tick(1);
    out_lit("replay", 1, 3, 0);
    bus.irq_ack = 1'b1; bus.epc_in = 32'h2000; tick(1); bus.irq_ack = 1'b0;
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    rd_lit("replay_pend", 8, 0);

    // withdrawn level request, spurious ack
    irq_src = 8'h10; tick(2);
    out_lit("wd_req", 1, 4, 0);
    irq_src = 8'h00; tick(1);
    out_lit("wd_hold", 1, 4, 0);
    tick(1);
    out_lit("wd_drop", 0, 4, 0);
    bus.irq_ack = 1'b1; tick(1); bus.irq_ack = 1'b0;
    out_lit("spurious", 0, 4, 0);
    rd_lit("wd_status", 12, 32'h004);

    // W1C versus simultaneous edge, plain W1C
    wr_reg(20, 0); wr_reg(4, 32'h4C);
    irq_src = 8'h40; tick(1); irq_src = 8'h00; tick(1);
    bus.addr = BASE + 8; bus.wdata = 32'h40; bus.wr = 1'b1; irq_src = 8'h40;
    tick(1); bus.wr = 1'b0;
    rd_lit("w1c_setwins", 8, 32'h40);
    wr_reg(8, 32'h40);
    rd_lit("w1c_clear", 8, 0);
    irq_src = 8'h00; tick(1);

    // global enable gating
    irq_src = 8'h40; tick(1); irq_src = 8'h00; tick(3);
    out_lit("gctrl_off", 0, 4, 0);
    rd_lit("gctrl_pend", 8, 32'h40);
    wr_reg(20, 1);
    out_lit("gctrl_wr", 0, 4, 0);
    tick(1);
    out_lit("gctrl_on", 1, 6, 0);

    // ack beats a same-cycle EPC write
    bus.addr = BASE + 16; bus.wdata = 32'hDEAD; bus.wr = 1'b1;
    bus.irq_ack = 1'b1; bus.epc_in = 32'h6000;
    tick(1); bus.wr = 1'b0; bus.irq_ack = 1'b0;
    out_lit("ack6", 0, 6, 1);
    rd_lit("epc_ack_wins", 16, 32'h6000);
    wr_reg(16, 32'h1234);
    rd_lit("epc_write", 16, 32'h1234);
    rd_lit("out_of_window", 32'h18, 0);
    bus.addr = BASE + 16;
    #1;
    lit("rd_low", bus.rdata, 0, m_read(bus.rd, bus.addr));

    // reset during service
    reset = 1'b1; tick(1);
    out_lit("rst_svc", 0, 0, 0);
    reset = 1'b0; tick(2);
    out_lit("post_rst", 0, 0, 0);
    rd_lit("post_rst_en", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised, memory-mapped interrupt controller for the pipelined MIPS core. It replaces the single `irqout` line from the peripheral block with NUM_SRC prioritised sources, each configurable as level- or edge-triggered. It runs a request/acknowledge/return handshake with the pipeline and captures the exception PC on acknowledge. It sits on the MEM-stage data bus beside the peripheral block.

## Interface
- NUM_SRC, 8, number of interrupt sources (1..32)
- ID_W, 3, width of source id; must equal ceil(log2(NUM_SRC)), minimum 1
- BASE, 32'h40000100, word-aligned base address of the register window

- clk  in  1  core clock (divided clock, same as pipeline)
- reset  in  1  synchronous, active-high; all state cleared on the rising clk edge where reset=1
- irq_src  in  NUM_SRC  interrupt sources, synchronous to clk; bit 0 is highest priority
- rd  in  1  bus read strobe (MEM stage)
- wr  in  1  bus write strobe (MEM stage)
- addr  in  32  bus byte address
- wdata  in  32  bus write data
- rdata  out  32  bus read data; combinational
- irq_req  out  1  registered interrupt request to pipeline
- irq_id  out  ID_W  registered id of requested or in-service source
- irq_ack  in  1  pipeline has flushed and taken the interrupt; sampled only in REQ
- eret  in  1  return-from-interrupt executed; sampled only in SERVICE
- epc_in  in  32  PC to save, valid while irq_ack=1
- in_service  out  1  high in SERVICE state

## Operation
- Registers at BASE+offset. Unused bits read 0. Bits at or above NUM_SRC read 0 and ignore writes.
  - 0x00 ENABLE: RW
  - 0x04 MODE: RW; 1=edge, 0=level
  - 0x08 PENDING: R; write-1-clears edge bits; level bits are read-only
  - 0x0C STATUS: R, {in_service at bit 8, irq_id at [ID_W-1:0]}
  - 0x10 EPC: RW
  - 0x14 GCTRL: bit0 = global enable, RW
- Pending:
  - Edge source: pending bit set on a 0→1 transition of irq_src versus its registered previous value.
  - Level source: pending = live irq_src.
  - Same cycle edge-set and W1C on a bit: set wins.
  - Changing MODE clears that bit's edge pending.
- eligible = PENDING & ENABLE, gated by GCTRL[0]. Winner = lowest set index.
- FSM, reset state IDLE:
  - IDLE → REQ when eligible≠0. irq_req=1, irq_id=winner.
  - REQ: irq_id re-evaluated every cycle. REQ → IDLE if eligible becomes 0, with irq_req dropping the next cycle. REQ → SERVICE on irq_ack. On that ack: irq_id is frozen, EPC←epc_in, and the edge pending of the taken id is cleared.
  - SERVICE: irq_req=0, in_service=1. No nesting; new pending bits accumulate. SERVICE → IDLE on eret.
  - irq_ack outside REQ and eret outside SERVICE are ignored.
  - A bus write to EPC in the same cycle as an ack capture: ack capture wins.
- Reset values: irq_req=0, irq_id=0, in_service=0, ENABLE=0, MODE=0, edge pending=0, EPC=0, GCTRL=0, previous-src register=0.
- Reset asserted mid-REQ or mid-SERVICE returns to IDLE with no further request.
- rdata is 0 when rd=0 or addr is outside the window.

## Timing
- Register writes take effect on the clk edge where wr=1. Eligibility uses the new value from the next cycle on.
- Source latency: irq_src first samples high at edge N. PENDING reads set after N. irq_req is high after edge N+1 (2-cycle latency).
- Ack: irq_ack high at edge M → after M, irq_req=0, in_service=1, EPC valid.
- eret at edge K → IDLE after K. If eligible≠0, irq_req re-asserts after K+1. There is always at least one idle cycle between requests.
- Reads have zero latency: rdata reflects register state before the current edge.

## Test plan
- Reset then idle: hold reset 2 cycles, pulse irq_src → irq_req=0, rdata at 0x08 = 0, EPC = 0.
- Edge + ack: ENABLE=0xFF, MODE=0x04, GCTRL=1; pulse irq_src[2] one cycle → irq_req=1 and irq_id=2 two edges later. Ack with epc_in=0x00000238 → in_service=1, EPC reads 0x00000238, PENDING bit2=0.
- Priority/preemption in REQ: level src5 high → irq_id=5. Then raise src1 before ack → irq_id=1 next cycle. Ack → irq_id stays 1 even after src0 rises.
- No nesting + replay: in SERVICE, pulse edge src3 → irq_req stays 0 and PENDING bit3=1. eret → irq_req=1, irq_id=3 two edges later.
- Withdraw: level src4 high then low before ack → irq_req drops one cycle after src4 falls, FSM back in IDLE, spurious irq_ack ignored (in_service stays 0).
- Boundaries: W1C on bit6 in the same cycle as a src6 rising edge → bit6 stays set. GCTRL=0 with pending → no request. Reset during SERVICE → in_service=0 next cycle.
